phys_mem_ctrl: RTL and testbench

- Responder end of the CPU physical-memory interface (`addr` / `data` / `is_write` / `busy`). Sits between the CPU's MMU-facing memory port and the board's 32-bit asynchronous SRAM.
- Converts each CPU word access into a timed SRAM read or write cycle.
- Holds `busy` high until the access completes.
- Keeps a single-word read-hit register, so repeated instruction and data fetches of the same word do not stall.

---
 rtl/phys_mem_ctrl_pkg.sv | 21 ++
 rtl/phys_mem_ctrl_if.sv | 27 ++
 rtl/phys_mem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_phys_mem_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/phys_mem_ctrl_pkg.sv
// Shared types for the CPU physical-memory responder: the FSM state encoding
// and the sizing helper for the SRAM wait counter.
package phys_mem_ctrl_pkg;

    localparam int PHYS_MEM_STATE_WIDTH = 3;

    typedef enum logic [PHYS_MEM_STATE_WIDTH-1:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } pm_state_e;

    // Counter must reach max(READ_WAIT, WRITE_WAIT)-1 without wrapping.
    function automatic int wait_cnt_width(input int read_wait, input int write_wait);
        return $clog2((read_wait > write_wait) ? read_wait : write_wait) + 1;
    endfunction

endpackage

// File: rtl/phys_mem_ctrl_if.sv
// CPU-side physical-memory port: the CPU drives the request, the controller
// answers with read data and a combinational busy.
interface phys_mem_ctrl_if;

    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_is_write;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;

    modport master (
        output cpu_addr,
        output cpu_wdata,
        output cpu_is_write,
        input  cpu_rdata,
        input  cpu_busy
    );

    modport slave (
        input  cpu_addr,
        input  cpu_wdata,
        input  cpu_is_write,
        output cpu_rdata,
        output cpu_busy
    );

endinterface

// File: rtl/phys_mem_ctrl.sv
// Turns CPU word accesses into timed asynchronous-SRAM read/write cycles and
// keeps a one-word read-hit register so repeated fetches of a word never stall.
module phys_mem_ctrl
    import phys_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    phys_mem_ctrl_if.slave        cpu,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [31:0]           sram_dq_in,
    output logic [31:0]           sram_dq_out,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam int CNT_W = wait_cnt_width(READ_WAIT, WRITE_WAIT);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_WAIT - 1);

    pm_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hit_valid_q, hit_valid_d;
    logic [ADDR_WIDTH-1:0] hit_addr_q, hit_addr_d;
    logic [31:0]           hit_data_q, hit_data_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]           dq_out_q, dq_out_d;
    logic                  dq_oe_q, dq_oe_d;
    logic                  ce_n_q, ce_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  in_range;
    logic                  hit;
    logic                  addr_lo_unused;

    assign word_addr      = cpu.cpu_addr[ADDR_WIDTH+1:2];
    assign in_range       = (cpu.cpu_addr[31:ADDR_WIDTH+2] == '0);
    assign hit            = !cpu.cpu_is_write && hit_valid_q && (word_addr == hit_addr_q);
    assign addr_lo_unused = ^cpu.cpu_addr[1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hit_valid_d = hit_valid_q;
        hit_addr_d  = hit_addr_q;
        hit_data_d  = hit_data_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!hit) begin
                    if (!in_range) begin
                        // Out-of-range: reads return zero, writes vanish, no SRAM strobe.
                        if (!cpu.cpu_is_write) begin
                            rdata_d = '0;
                        end
                        state_d = ST_DONE;
                    end else if (!cpu.cpu_is_write) begin
                        sram_addr_d = word_addr;
                        ce_n_d      = 1'b0;
                        oe_n_d      = 1'b0;
                        cnt_d       = '0;
                        state_d     = ST_RD;
                    end else begin
                        sram_addr_d = word_addr;
                        dq_out_d    = cpu.cpu_wdata;
                        dq_oe_d     = 1'b1;
                        ce_n_d      = 1'b0;
                        state_d     = ST_WR_SETUP;
                    end
                end
            end
            ST_RD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == RD_LAST) begin
                    rdata_d     = sram_dq_in;
                    hit_data_d  = sram_dq_in;
                    hit_addr_d  = sram_addr_q;
                    hit_valid_d = 1'b1;
                    ce_n_d      = 1'b1;
                    oe_n_d      = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == WR_LAST) begin
                    we_n_d  = 1'b1;
                    state_d = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                state_d = ST_DONE;
                // Keep the hit word coherent with what was just written.
                if (sram_addr_q == hit_addr_q) begin
                    rdata_d    = dq_out_q;
                    hit_data_d = dq_out_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hit_valid_q <= 1'b0;
            hit_addr_q  <= '0;
            hit_data_q  <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hit_valid_q <= hit_valid_d;
            hit_addr_q  <= hit_addr_d;
            hit_data_q  <= hit_data_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
        end
    end

    // Busy is held low while reset is asserted so the CPU never waits on a dead controller.
    always_comb begin
        cpu.cpu_busy = 1'b1;
        case (state_q)
            ST_IDLE: cpu.cpu_busy = !hit;
            ST_DONE: cpu.cpu_busy = 1'b0;
            default: cpu.cpu_busy = 1'b1;
        endcase
        if (!rst) begin
            cpu.cpu_busy = 1'b0;
        end
    end

    // A hit is answered from the hit register even if an out-of-range read zeroed rdata_q.
    assign cpu.cpu_rdata = (state_q == ST_IDLE && hit) ? hit_data_q : rdata_q;

    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_phys_mem_ctrl.sv
// Self-checking bench for phys_mem_ctrl: a behavioural SRAM, a transaction-level
// CPU model with a one-word hit register, directed cases and random traffic.
module tb_phys_mem_ctrl;

    localparam int AW = 20;
    localparam int RW = 2;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_dq_in;
    logic [31:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    phys_mem_ctrl_if bus ();

    phys_mem_ctrl #(.ADDR_WIDTH(AW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu         (bus),
        .sram_addr   (sram_addr),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;
    bit sram_init = 1'b1;

    function automatic logic [31:0] init_word(input int w);
        logic [31:0] v;
        v = 32'(w) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
        if (w == 4) v = 32'hDEAD_BEEF;
        return v;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    // Behavioural asynchronous SRAM (4K words are enough for the stimulus used).
    logic [31:0] sram_mem [0:4095];
    always @(posedge clk) begin
        if (sram_init) begin
            for (int i = 0; i < 4096; i++) sram_mem[i] <= init_word(i);
        end else if (!sram_ce_n && !sram_we_n) begin
            sram_mem[sram_addr[11:0]] <= sram_dq_out;
        end
    end
    always_comb begin
        sram_dq_in = 32'hBAD0_BAD0;
        if (!sram_ce_n && !sram_oe_n) sram_dq_in = sram_mem[sram_addr[11:0]];
    end

    // Reference model of what the CPU must observe.
    logic [31:0] mem_m [0:4095];
    bit          hv_m;
    logic [AW-1:0] ha_m;
    logic [31:0] hd_m;

    // Per-cycle bus-safety checks.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("no_oe_with_dq_oe", 32'(!sram_oe_n && sram_dq_oe), 32'd0);
            if (!sram_we_n) chk("we_needs_ce_and_dq_oe", 32'(!sram_ce_n && sram_dq_oe && sram_oe_n), 32'd1);
        end
    end

    int          o_nb, o_oe, o_we, o_ce, o_dq;
    logic [31:0] o_rd;
    logic [AW-1:0] o_sa;

    // Present one request and watch it until busy drops.
    task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input bit wr);
        bit done = 0;
        bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_is_write = wr;
        o_nb = 0; o_oe = 0; o_we = 0; o_ce = 0; o_dq = 0; o_rd = '0; o_sa = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!sram_oe_n) o_oe++;
            if (!sram_we_n) o_we++;
            if (sram_dq_oe) o_dq++;
            if (!sram_ce_n) begin o_ce++; o_sa = sram_addr; end
            if (!bus.cpu_busy) begin o_rd = bus.cpu_rdata; done = 1; break; end
            o_nb++;
        end
        if (!done) chk("busy_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic model_access(input logic [31:0] a, input logic [31:0] wd, input bit wr);
        bit            in_r = (a[31:AW+2] == '0);
        logic [AW-1:0] wa   = a[AW+1:2];
        run_access(a, wd, wr);
        if (!in_r) begin
            chk("oor_busy", o_nb, 1);
            chk("oor_no_ce", o_ce, 0);
            if (!wr) chk("oor_rdata", o_rd, 0);
        end else if (!wr && hv_m && wa == ha_m) begin
            chk("hit_busy", o_nb, 0);
            chk("hit_no_ce", o_ce, 0);
            chk("hit_rdata", o_rd, hd_m);
        end else if (!wr) begin
            chk("miss_busy", o_nb, 1 + RW);
            chk("miss_oe_cycles", o_oe, RW);
            chk("miss_we_cycles", o_we, 0);
            chk("miss_addr", 32'(o_sa), 32'(wa));
            chk("miss_rdata", o_rd, mem_m[wa[11:0]]);
            hv_m = 1; ha_m = wa; hd_m = mem_m[wa[11:0]];
        end else begin
            chk("wr_busy", o_nb, 3 + WW);
            chk("wr_we_cycles", o_we, WW);
            chk("wr_oe_cycles", o_oe, 0);
            chk("wr_ce_cycles", o_ce, 2 + WW);
            chk("wr_dq_oe_cycles", o_dq, 2 + WW);
            chk("wr_addr", 32'(o_sa), 32'(wa));
            mem_m[wa[11:0]] = wd;
            if (wa == ha_m) hd_m = wd;
        end
    endtask

    initial begin
        logic [31:0] a, wd;
        bit          wr, seen;
        int          r;
        for (int i = 0; i < 4096; i++) mem_m[i] = init_word(i);
        hv_m = 0; ha_m = '0; hd_m = '0;
        rst = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_is_write = 1'b0;
        @(posedge clk); #1 sram_init = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_sram_addr", 32'(sram_addr), 0);
        chk("rst_dq_out", sram_dq_out, 0);
        chk("rst_rdata", bus.cpu_rdata, 0);
        chk("rst_busy", bus.cpu_busy, 0);
        mon_en = 1'b1;
        rst = 1'b1;

        // First read of word 4 misses and fetches DEADBEEF.
        model_access(32'h0000_0010, 32'h0, 0);
        chk("lit_rd_busy", o_nb, 3);
        chk("lit_rd_data", o_rd, 32'hDEAD_BEEF);
        chk("lit_rd_addr", 32'(o_sa), 4);
        chk("lit_rd_oe", o_oe, 2);
        model_access(32'h0000_0010, 32'h0, 0);
        chk("lit_hit_busy", o_nb, 0);
        chk("lit_hit_data", o_rd, 32'hDEAD_BEEF);
        model_access(32'h0000_0010, 32'h1234_5678, 1);
        chk("lit_wr_busy", o_nb, 5);
        chk("lit_wr_we", o_we, 2);
        chk("lit_wr_dq_oe", o_dq, 4);
        chk("lit_wr_sram", sram_mem[4], 32'h1234_5678);
        model_access(32'h0000_0010, 32'h0, 0);
        chk("lit_coherent_hit", o_rd, 32'h1234_5678);
        model_access(32'h0040_0000, 32'h0, 0);
        chk("lit_oor_rd", o_rd, 32'h0);
        model_access(32'hFFFF_FFF0, 32'hAAAA_5555, 1);
        chk("lit_oor_wr_we", o_we, 0);
        chk("lit_oor_wr_sram", sram_mem[12'hFFC], init_word(12'hFFC));
        model_access(32'h0000_0010, 32'h0, 0);
        chk("lit_hit_after_oor", o_rd, 32'h1234_5678);

        // Reset in the middle of a write pulse.
        bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hCAFE_F00D; bus.cpu_is_write = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!sram_we_n) begin seen = 1; break; end
        end
        chk("we_pulse_seen", 32'(seen), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_we_n", sram_we_n, 1);
        chk("abort_ce_n", sram_ce_n, 1);
        chk("abort_dq_oe", sram_dq_oe, 0);
        chk("abort_busy", bus.cpu_busy, 0);
        hv_m = 0; ha_m = '0; hd_m = '0;
        mem_m[4] = sram_mem[4];
        rst = 1'b1;
        model_access(32'h0000_0010, 32'h0, 0);
        chk("lit_miss_after_rst", o_nb, 3);

        // Single-entry hit register: alternating words always miss.
        for (int i = 0; i < 6; i++) begin
            model_access((i % 2) ? 32'h104 : 32'h100, 32'h0, 0);
            chk("alt_miss_busy", o_nb, 3);
        end

        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 9);
            wd = $urandom;
            wr = ($urandom_range(0, 2) == 0);
            if (r <= 5)      a = {18'h0, 10'($urandom_range(0, 15)), 2'($urandom)};
            else if (r <= 7) a = (r == 6) ? 32'h100 : 32'h104;
            else if (r == 8) begin a = $urandom; if (a[31:AW+2] == '0) a[31] = 1'b1; end
            else             a = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
            model_access(a, wd, wr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
